// File: rtl/commit_wb_arbiter_if.sv
// commit_wb_arbiter_if: execution-unit commit lanes in, one registered
// writeback beat out, plus the optional per-lane stall counters.
interface commit_wb_arbiter_if #(
    parameter int NUM_INPUTS = 4,
    parameter int DATAW      = 64,
    parameter int CTRW       = 16,
    parameter int SELW       = $clog2(NUM_INPUTS)
);
    logic [NUM_INPUTS-1:0]       valid_in;
    logic [NUM_INPUTS-1:0]       ready_in;
    logic [NUM_INPUTS*DATAW-1:0] data_in;
    logic [NUM_INPUTS-1:0]       sop_in;
    logic [NUM_INPUTS-1:0]       eop_in;
    logic                        valid_out;
    logic                        ready_out;
    logic [DATAW-1:0]            data_out;
    logic                        sop_out;
    logic                        eop_out;
    logic [SELW-1:0]             sel_out;
    logic [NUM_INPUTS*CTRW-1:0]  stall_cnt;

    modport master (
        output valid_in, data_in, sop_in, eop_in, ready_out,
        input  ready_in, valid_out, data_out, sop_out, eop_out,
        input  sel_out, stall_cnt
    );

    modport slave (
        input  valid_in, data_in, sop_in, eop_in, ready_out,
        output ready_in, valid_out, data_out, sop_out, eop_out,
        output sel_out, stall_cnt
    );
endinterface

// File: rtl/commit_wb_arbiter.sv
// commit_wb_arbiter: round-robin commit arbiter with packet lock and
// starvation guard; stall counters only exist with COMMIT_ARB_PERF_EN.
module commit_wb_arbiter #(
    parameter int NUM_INPUTS   = 4,
    parameter int DATAW        = 64,
    parameter int STARVE_LIMIT = 15,
    parameter int CTRW         = 16
) (
    input  logic              clk,
    input  logic              reset_n,
    commit_wb_arbiter_if.slave bus
);
    localparam int SELW = $clog2(NUM_INPUTS);
    localparam logic [7:0] LIMIT = 8'(STARVE_LIMIT);

    typedef enum logic {
        IDLE,
        LOCKED
    } lock_state_e;

    lock_state_e state_q, state_d;
    logic [SELW-1:0] lock_idx_q, lock_idx_d;
    logic [SELW-1:0] rr_ptr_q;
    logic [7:0]      starve_q [NUM_INPUTS];

    logic             valid_q;
    logic             sop_q;
    logic             eop_q;
    logic [DATAW-1:0] data_q;
    logic [SELW-1:0]  sel_q;

    logic                  load_en;
    logic                  locked;
    logic                  starve_hit;
    logic [SELW-1:0]       starve_idx;
    logic                  rr_hit;
    logic [SELW-1:0]       rr_idx;
    logic                  grant_any;
    logic [SELW-1:0]       grant_idx;
    logic [NUM_INPUTS-1:0] grant;
    logic [NUM_INPUTS-1:0] ready;
    logic [NUM_INPUTS-1:0] fire;
    logic                  fire_any;
    logic                  fire_eop;
    logic [DATAW-1:0]      fire_data;

    assign load_en = !valid_q || bus.ready_out;
    assign locked  = (state_q == LOCKED);

    // Descending scan so the lowest starved index wins.
    always_comb begin : starve_pick
        starve_hit = 1'b0;
        starve_idx = '0;
        for (int i = NUM_INPUTS - 1; i >= 0; i--) begin
            if (bus.valid_in[i] && starve_q[i] == LIMIT) begin
                starve_hit = 1'b1;
                starve_idx = SELW'(i);
            end
        end
    end

    always_comb begin : rr_pick
        logic [SELW-1:0] j;
        rr_hit = 1'b0;
        rr_idx = '0;
        j      = '0;
        for (int k = NUM_INPUTS; k >= 1; k--) begin
            j = SELW'((int'(rr_ptr_q) + k) % NUM_INPUTS);
            if (bus.valid_in[j]) begin
                rr_hit = 1'b1;
                rr_idx = j;
            end
        end
    end

    always_comb begin : grant_pick
        grant_any = 1'b0;
        grant_idx = '0;
        unique case (1'b1)
            locked: begin
                grant_any = 1'b1;
                grant_idx = lock_idx_q;
            end
            (!locked && starve_hit): begin
                grant_any = 1'b1;
                grant_idx = starve_idx;
            end
            (!locked && !starve_hit && rr_hit): begin
                grant_any = 1'b1;
                grant_idx = rr_idx;
            end
            default: begin
                grant_any = 1'b0;
                grant_idx = '0;
            end
        endcase
    end

    assign grant     = grant_any ? (NUM_INPUTS'(1) << grant_idx) : '0;
    // Reset gating keeps every lane blocked while reset_n is low.
    assign ready     = grant & {NUM_INPUTS{load_en & reset_n}};
    assign fire      = bus.valid_in & ready;
    assign fire_any  = |fire;
    assign fire_eop  = bus.eop_in[grant_idx];
    assign fire_data = bus.data_in[int'(grant_idx)*DATAW +: DATAW];

    always_comb begin : lock_next
        state_d    = state_q;
        lock_idx_d = lock_idx_q;
        unique case (state_q)
            IDLE: begin
                if (fire_any && !fire_eop) begin
                    state_d    = LOCKED;
                    lock_idx_d = grant_idx;
                end
            end
            LOCKED: begin
                if (fire_any && fire_eop) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            lock_idx_q <= '0;
            rr_ptr_q   <= SELW'(NUM_INPUTS - 1);
        end else begin
            state_q    <= state_d;
            lock_idx_q <= lock_idx_d;
            if (fire_any) begin
                rr_ptr_q <= grant_idx;
            end
        end
    end

    // Downstream backpressure is not starvation, so counters need load_en.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NUM_INPUTS; i++) begin
                starve_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_INPUTS; i++) begin
                if (fire[i]) begin
                    starve_q[i] <= '0;
                end else if (bus.valid_in[i] && !ready[i] && load_en &&
                             starve_q[i] != LIMIT) begin
                    starve_q[i] <= starve_q[i] + 8'd1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            sop_q   <= 1'b0;
            eop_q   <= 1'b0;
            sel_q   <= '0;
        end else if (load_en) begin
            valid_q <= fire_any;
            if (fire_any) begin
                data_q <= fire_data;
                sop_q  <= bus.sop_in[grant_idx];
                eop_q  <= fire_eop;
                sel_q  <= grant_idx;
            end
        end
    end

    assign bus.ready_in  = ready;
    assign bus.valid_out = valid_q;
    assign bus.data_out  = data_q;
    assign bus.sop_out   = sop_q;
    assign bus.eop_out   = eop_q;
    assign bus.sel_out   = sel_q;

`ifdef COMMIT_ARB_PERF_EN
    logic [CTRW-1:0] stall_q [NUM_INPUTS];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NUM_INPUTS; i++) begin
                stall_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_INPUTS; i++) begin
                if (bus.valid_in[i] && !ready[i]) begin
                    stall_q[i] <= stall_q[i] + CTRW'(1);
                end
            end
        end
    end

    for (genvar g = 0; g < NUM_INPUTS; g++) begin : g_stall
        assign bus.stall_cnt[g*CTRW +: CTRW] = stall_q[g];
    end
`else
    assign bus.stall_cnt = '0;
`endif

endmodule

// File: tb/tb_commit_wb_arbiter.sv
// tb_commit_wb_arbiter: directed vector table, corner-case sequences and
// random traffic against a behavioural model of the arbitration rules.
module tb_commit_wb_arbiter;
    localparam int N   = 4;
    localparam int DW  = 64;
    localparam int LIM = 3;
    localparam int CW  = 16;
    localparam int SW  = 2;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    commit_wb_arbiter_if #(.NUM_INPUTS(N), .DATAW(DW), .CTRW(CW)) bus ();

    commit_wb_arbiter #(
        .NUM_INPUTS(N), .DATAW(DW), .STARVE_LIMIT(LIM), .CTRW(CW)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .bus(bus)
    );

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    string phase = "init";

    bit          m_lock;
    int          m_lidx;
    int          m_rr;
    int          m_cnt [N];
    int          m_stall [N];
    bit          m_vo, m_sop, m_eop;
    int          m_sel;
    logic [63:0] m_data;

    typedef struct {
        logic [N-1:0] v, s, e;
        logic         ro;
        logic [N-1:0] rdy;
        logic         vo;
        int           sel;
        logic         sop, eop;
    } vec_t;

    vec_t tbl [14];

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s/%s: got %0h expected %0h", phase, name, act, exp);
        end
    endtask

    function automatic void m_reset();
        m_lock = 0;
        m_lidx = 0;
        m_rr   = N - 1;
        for (int i = 0; i < N; i++) begin
            m_cnt[i]   = 0;
            m_stall[i] = 0;
        end
        m_vo = 0; m_sop = 0; m_eop = 0; m_sel = 0; m_data = '0;
    endfunction

    function automatic int m_grant();
        if (m_lock) return m_lidx;
        for (int i = 0; i < N; i++)
            if (bus.valid_in[i] && m_cnt[i] == LIM) return i;
        for (int k = 1; k <= N; k++)
            if (bus.valid_in[(m_rr + k) % N]) return (m_rr + k) % N;
        return -1;
    endfunction

    function automatic logic [N-1:0] m_ready();
        logic [N-1:0] r = '0;
        int g = m_grant();
        if (g >= 0 && (!m_vo || bus.ready_out)) r[g] = 1'b1;
        return r;
    endfunction

    function automatic logic [N*CW-1:0] m_stall_vec();
        logic [N*CW-1:0] v = '0;
`ifdef COMMIT_ARB_PERF_EN
        for (int i = 0; i < N; i++) v[i*CW +: CW] = CW'(m_stall[i]);
`endif
        return v;
    endfunction

    function automatic void m_advance();
        logic [N-1:0] r = m_ready();
        int  g    = m_grant();
        bit  load = !m_vo || bus.ready_out;
        bit  fired = (g >= 0) && load && bus.valid_in[g];
        for (int i = 0; i < N; i++) begin
            if (bus.valid_in[i] && !r[i]) m_stall[i] = (m_stall[i] + 1) % (1 << CW);
            if (fired && i == g) m_cnt[i] = 0;
            else if (bus.valid_in[i] && !r[i] && load && m_cnt[i] < LIM) m_cnt[i]++;
        end
        if (fired) begin
            if (!m_lock && !bus.eop_in[g]) begin
                m_lock = 1;
                m_lidx = g;
            end else if (m_lock && bus.eop_in[g]) begin
                m_lock = 0;
            end
            m_rr = g;
        end
        if (load) begin
            m_vo = fired;
            if (fired) begin
                m_data = bus.data_in[g*DW +: DW];
                m_sop  = bus.sop_in[g];
                m_eop  = bus.eop_in[g];
                m_sel  = g;
            end
        end
    endfunction

    task automatic drive(input logic [N-1:0] v, s, e, input logic ro);
        bus.valid_in  = v;
        bus.sop_in    = s;
        bus.eop_in    = e;
        bus.ready_out = ro;
        for (int i = 0; i < N; i++)
            bus.data_in[i*DW +: DW] = {8'(i), 24'h0, 32'(cyc)};
        cyc++;
    endtask

    task automatic step();
        #1;
        check("out", 64'({bus.valid_out, bus.sop_out, bus.eop_out, bus.sel_out}),
              64'({m_vo, m_sop, m_eop, SW'(m_sel)}));
        check("data", bus.data_out, m_data);
        check("ready", 64'(bus.ready_in), 64'(m_ready()));
        check("stall", 64'(bus.stall_cnt), 64'(m_stall_vec()));
        m_advance();
        @(negedge clk);
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        drive('0, '0, '0, 1'b1);
        m_reset();
        @(negedge clk);
        #1;
        check("reset.out", 64'({bus.valid_out, bus.sop_out, bus.eop_out, bus.sel_out}), 64'(0));
        check("reset.data", bus.data_out, 64'(0));
        check("reset.ready", 64'(bus.ready_in), 64'(0));
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    initial begin
        logic [63:0] held_data;
        int          held_sel;

        tbl[0]  = '{4'b1111, 4'b1111, 4'b1111, 1, 4'b0001, 0, 0, 0, 0};
        tbl[1]  = '{4'b1111, 4'b1111, 4'b1111, 1, 4'b0010, 1, 0, 1, 1};
        tbl[2]  = '{4'b1111, 4'b1111, 4'b1111, 1, 4'b0100, 1, 1, 1, 1};
        tbl[3]  = '{4'b1111, 4'b1111, 4'b1111, 1, 4'b1000, 1, 2, 1, 1};
        tbl[4]  = '{4'b1111, 4'b1111, 4'b1111, 1, 4'b0001, 1, 3, 1, 1};
        tbl[5]  = '{4'b0000, 4'b0000, 4'b0000, 1, 4'b0000, 1, 0, 1, 1};
        tbl[6]  = '{4'b0000, 4'b0000, 4'b0000, 1, 4'b0000, 0, 0, 0, 0};
        tbl[7]  = '{4'b0101, 4'b0101, 4'b0001, 1, 4'b0100, 0, 0, 0, 0};
        tbl[8]  = '{4'b0001, 4'b0001, 4'b0001, 1, 4'b0100, 1, 2, 1, 0};
        tbl[9]  = '{4'b0001, 4'b0001, 4'b0001, 1, 4'b0100, 0, 0, 0, 0};
        tbl[10] = '{4'b0101, 4'b0001, 4'b0001, 1, 4'b0100, 0, 0, 0, 0};
        tbl[11] = '{4'b0101, 4'b0001, 4'b0101, 1, 4'b0100, 1, 2, 0, 0};
        tbl[12] = '{4'b0001, 4'b0001, 4'b0001, 1, 4'b0001, 1, 2, 0, 1};
        tbl[13] = '{4'b0000, 4'b0000, 4'b0000, 1, 4'b0000, 1, 0, 1, 1};

        phase = "reset";
        do_reset();

        phase = "table";
        for (int r = 0; r < 14; r++) begin
            drive(tbl[r].v, tbl[r].s, tbl[r].e, tbl[r].ro);
            #1;
            check($sformatf("row%0d.ready", r), 64'(bus.ready_in), 64'(tbl[r].rdy));
            check($sformatf("row%0d.valid", r), 64'(bus.valid_out), 64'(tbl[r].vo));
            if (tbl[r].vo)
                check($sformatf("row%0d.beat", r),
                      64'({bus.sel_out, bus.sop_out, bus.eop_out}),
                      64'({SW'(tbl[r].sel), tbl[r].sop, tbl[r].eop}));
            step();
        end

        phase = "backpressure";
        drive(4'b0011, 4'b0011, 4'b0011, 1'b1);
        step();
        held_data = m_data;
        held_sel  = m_sel;
        for (int k = 0; k < 5; k++) begin
            drive(4'b0111, 4'b0111, 4'b0111, 1'b0);
            bus.data_in = {$urandom, $urandom, $urandom, $urandom,
                           $urandom, $urandom, $urandom, $urandom};
            #1;
            check("hold.ready", 64'(bus.ready_in), 64'(0));
            check("hold.data", bus.data_out, held_data);
            check("hold.sel", 64'(bus.sel_out), 64'(held_sel));
            step();
        end
        for (int k = 0; k < 4; k++) begin
            drive(4'b0111, 4'b0111, 4'b0111, 1'b1);
            step();
        end

        phase = "starve";
        do_reset();
        drive(4'b1000, 4'b1000, 4'b0000, 1'b1);
        #1 check("lock3", 64'(bus.ready_in), 64'(4'b1000));
        step();
        for (int k = 2; k <= 9; k++) begin
            drive(4'b1010, 4'b0010, 4'b0010, 1'b1);
            #1 check("blocked1", 64'(bus.ready_in[1]), 64'(0));
            step();
        end
        drive(4'b1011, 4'b0011, 4'b1011, 1'b1);
        #1 check("eop3", 64'(bus.ready_in), 64'(4'b1000));
        step();
        drive(4'b0011, 4'b0011, 4'b0011, 1'b1);
        #1 check("priority1", 64'(bus.ready_in), 64'(4'b0010));
        step();
        drive('0, '0, '0, 1'b1);
        step();

        phase = "areset";
        drive(4'b0100, 4'b0100, 4'b0000, 1'b1);
        step();
        drive(4'b0101, 4'b0101, 4'b0001, 1'b1);
        step();
        #3 reset_n = 1'b0;
        #1;
        check("valid", 64'(bus.valid_out), 64'(0));
        check("ready", 64'(bus.ready_in), 64'(0));
        m_reset();
        @(negedge clk);
        reset_n = 1'b1;
        drive(4'b0101, 4'b0101, 4'b0101, 1'b1);
        #1 check("first", 64'(bus.ready_in), 64'(4'b0001));
        step();
        drive(4'b0101, 4'b0101, 4'b0101, 1'b1);
        step();

        phase = "perf";
        do_reset();
        drive(4'b0001, 4'b0001, 4'b0000, 1'b1);
        step();
        for (int k = 1; k <= 7; k++) begin
            drive(4'b0011, 4'b0010, (k == 7) ? 4'b0011 : 4'b0010, 1'b1);
            step();
        end
        drive(4'b0010, 4'b0010, 4'b0010, 1'b1);
        step();
        drive('0, '0, '0, 1'b1);
        #1;
`ifdef COMMIT_ARB_PERF_EN
        check("stall1", 64'(bus.stall_cnt[CW +: CW]), 64'(7));
`else
        check("stall1", 64'(bus.stall_cnt[CW +: CW]), 64'(0));
`endif
        step();

        phase = "random";
        for (int k = 0; k < 800; k++) begin
            logic [N-1:0] e;
            for (int i = 0; i < N; i++) e[i] = ($urandom_range(2) == 0);
            drive(N'($urandom), N'($urandom), e, $urandom_range(3) != 0);
            for (int i = 0; i < N; i++)
                bus.data_in[i*DW +: DW] = {$urandom, $urandom};
            step();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
